// File: rtl/pc_fetch_if.sv
// Fetch PC controller bus: hazard-unit/decode controls in, fetch address and status out.
interface pc_fetch_if #(
    parameter int unsigned PC_W = 32
);
    logic            stall_i;
    logic            redirect_i;
    logic [PC_W-1:0] target_i;
    logic            fetch_ready_i;
    logic [PC_W-1:0] pc_o;
    logic            fetch_valid_o;
    logic            flush_o;
    logic            busy_o;

    // Hazard unit / decode side
    modport master (
        output stall_i, redirect_i, target_i, fetch_ready_i,
        input  pc_o, fetch_valid_o, flush_o, busy_o
    );

    // Fetch controller side
    modport slave (
        input  stall_i, redirect_i, target_i, fetch_ready_i,
        output pc_o, fetch_valid_o, flush_o, busy_o
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch-side PC controller: advances on accepted fetches, loads a branch target on a
// redirect edge, flushes fetch/decode and drains for BUBBLE_CYCLES before resuming.
// Optional macro PC_FETCH_REDIRECT_CNT_EN adds a saturating 16-bit redirect counter.
module pc_fetch_ctrl #(
    parameter int unsigned   PC_W          = 32,
    parameter int unsigned   PC_STEP       = 4,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int unsigned   BUBBLE_CYCLES = 3
) (
    input  logic          clk,
    input  logic          reset,
`ifdef PC_FETCH_REDIRECT_CNT_EN
    output logic [15:0]   redirect_cnt_o,
`endif
    pc_fetch_if.slave     bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   w_pc_nxt;
    logic              r_flush;
    logic              w_flush_nxt;
    logic              r_redirect_q;
    logic              w_redir_edge;
    logic              w_fetch_valid;

    assign w_redir_edge  = bus.redirect_i & ~r_redirect_q;
    // Combinational so a stall gates the fetch in the same cycle
    assign w_fetch_valid = (r_state == RUN) & ~bus.stall_i & ~reset;

    // State, PC, bubble counter, flush pulse and redirect history registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= RUN;
            r_cnt        <= '0;
            r_pc         <= RESET_PC;
            r_flush      <= 1'b0;
            r_redirect_q <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_pc         <= w_pc_nxt;
            r_flush      <= w_flush_nxt;
            r_redirect_q <= bus.redirect_i;
        end
    end

    // Next-state: redirect edge beats the fetch handshake; drain counts regardless of stall
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pc_nxt    = r_pc;
        w_flush_nxt = 1'b0;
        if (w_redir_edge) begin
            w_state_nxt = DRAIN;
            w_cnt_nxt   = CNT_W'(BUBBLE_CYCLES - 1);
            w_pc_nxt    = bus.target_i;
            w_flush_nxt = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_fetch_valid && bus.fetch_ready_i) begin
                        w_pc_nxt = r_pc + PC_W'(PC_STEP);
                    end
                end
                DRAIN: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    assign bus.pc_o          = r_pc;
    assign bus.fetch_valid_o = w_fetch_valid;
    assign bus.flush_o       = r_flush;
    assign bus.busy_o        = (r_state == DRAIN);

`ifdef PC_FETCH_REDIRECT_CNT_EN
    logic [15:0] r_redirect_cnt;

    // Saturating count of redirect edges
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_redirect_cnt <= '0;
        end else if (w_redir_edge && (r_redirect_cnt != 16'hFFFF)) begin
            r_redirect_cnt <= r_redirect_cnt + 16'd1;
        end
    end

    assign redirect_cnt_o = r_redirect_cnt;
`endif
endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch-side program-counter controller that consumes the branch-hazard unit's stall and PC-select outputs. Holds the architectural fetch PC, advances it on accepted fetches, and loads a branch target on a redirect request. After a redirect it flushes the fetch/decode pipeline register and inserts a fixed number of bubble cycles before fetching resumes.

## Interface
- PC_W, 32, program-counter width in bits
- PC_STEP, 4, increment added on each accepted fetch
- RESET_PC, 0, PC value loaded on reset
- BUBBLE_CYCLES, 3, bubble cycles inserted after a redirect (1..15)

- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high
- stall_i  in  1  hazard-unit stop signal; freezes PC advance
- redirect_i  in  1  hazard-unit PC-mux select; level, may be held for several cycles
- target_i  in  PC_W  branch target; sampled on the redirect edge only
- fetch_ready_i  in  1  decode stage accepts the current fetch
- pc_o  out  PC_W  current fetch address
- fetch_valid_o  out  1  pc_o is a valid fetch this cycle
- flush_o  out  1  one-cycle pulse; clear the fetch/decode pipeline register
- busy_o  out  1  redirect drain in progress

## Operation
- States: RUN, DRAIN.
- Redirect edge: `redir_edge = redirect_i & ~redirect_q`, where `redirect_q` is redirect_i registered.
- Only the edge acts. A held redirect_i does not reload the target.
- Priority at each posedge: reset, then redir_edge, then stall_i, then the fetch handshake.
- RUN:
  - On redir_edge: pc_o <= target_i, flush_o <= 1, cnt <= BUBBLE_CYCLES-1, go to DRAIN.
  - Else, if fetch_valid_o & fetch_ready_i: pc_o <= pc_o + PC_STEP, modulo 2^PC_W. Wrap from all-ones is silent.
  - Else: hold pc_o.
- DRAIN:
  - pc_o holds the target. fetch_valid_o = 0. busy_o = 1.
  - cnt decrements every cycle, regardless of stall_i.
  - When cnt == 0, go to RUN.
  - On redir_edge in DRAIN: load the new target, pulse flush_o again, restart cnt at BUBBLE_CYCLES-1.
- fetch_valid_o = (state == RUN) & ~stall_i. This is combinational so a stall takes effect in the same cycle.
- flush_o is registered and high for exactly one cycle per redir_edge.
- target_i is used unmodified. Alignment is the hazard unit's responsibility.

## Timing
- Reset values: pc_o = RESET_PC, fetch_valid_o = 0 while reset is asserted, flush_o = 0, busy_o = 0, state RUN, cnt = 0, redirect_q = 0.
- Reset mid-DRAIN aborts the drain immediately, with no flush pulse.
- If redirect_i is already high when reset deasserts, the first posedge sees an edge (redirect_q = 0) and performs a redirect.
- Redirect latency: redir_edge sampled at edge N gives the following.
  - pc_o = target and flush_o = 1 during cycle N+1.
  - fetch_valid_o = 0 for BUBBLE_CYCLES cycles, N+1 through N+BUBBLE_CYCLES.
  - fetch_valid_o = 1 with pc_o = target in cycle N+BUBBLE_CYCLES+1, if stall_i is low.
- Advance latency: handshake at edge N gives pc_o + PC_STEP visible in N+1.
- Simultaneous redir_edge and handshake: the redirect wins. The accepted fetch is discarded by flush_o.
- Simultaneous redir_edge and stall_i: the redirect is taken. The stall only gates advance.

## Configuration
- Macro: PC_FETCH_REDIRECT_CNT_EN.
- Defined:
  - Adds output port `redirect_cnt_o  out  16`, a count of redir_edge events.
  - The count saturates at 16'hFFFF and resets to 0.
- Undefined:
  - The port and counter do not exist.
  - All other behaviour is identical.

## Test plan
- Reset release, stall_i = 0, fetch_ready_i = 1 for 4 cycles -> pc_o = 0, 4, 8, 12. fetch_valid_o = 1 every cycle.
- stall_i = 1 for 2 cycles at pc_o = 8 -> fetch_valid_o = 0 and pc_o stays 8. Advance resumes to 12 the cycle after stall_i drops.
- redirect_i held high 4 cycles with target_i = 0x100, BUBBLE_CYCLES = 3 -> flush_o pulses once. busy_o = 1 for 3 cycles. Then fetch_valid_o = 1 with pc_o = 0x100. No second reload.
- Second redirect edge (target 0x200) during DRAIN of 0x100 -> second flush_o pulse, counter restarts, first valid fetch at pc_o = 0x200 three bubbles later.
- pc_o = 0xFFFFFFFC with a handshake -> pc_o = 0x00000000, no other side effects.
- reset asserted mid-DRAIN -> pc_o = RESET_PC, busy_o = 0, flush_o = 0 at once. With PC_FETCH_REDIRECT_CNT_EN defined, redirect_cnt_o = 0.
